// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state encoding and helpers for the pipe world model
package pipe_pkg;

  localparam int ROWS_DEF      = 10;
  localparam int COLS_DEF      = 20;
  localparam int MAX_MOVES_DEF = 511;

  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] SOUTH = 2'b01;
  localparam logic [1:0] EAST  = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;

  localparam logic [2:0] CELL_FREE  = 3'd0;
  localparam logic [2:0] CELL_WALL  = 3'd1;
  localparam logic [2:0] CELL_TRASH = 3'd2;
  localparam logic [2:0] CELL_UNDER = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // Coordinates carry one extra bit so row/col 0 and ROWS+1/COLS+1 are representable.
  function automatic logic in_map(input logic [4:0] r, input logic [5:0] c,
                                  input logic [4:0] row_max, input logic [5:0] col_max);
    return (r != 5'd0) && (r <= row_max) && (c != 6'd0) && (c <= col_max);
  endfunction

  function automatic logic [1:0] turn_left(input logic [1:0] d);
    case (d)
      NORTH:   return WEST;
      WEST:    return SOUTH;
      SOUTH:   return EAST;
      default: return NORTH;
    endcase
  endfunction

endpackage

// File: rtl/pipe_neighbour_lookup.sv
// rtl/pipe_neighbour_lookup.sv - ahead/left cell coordinates and off-map flags for a pose
module pipe_neighbour_lookup
  import pipe_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [3:0] row,
  input  logic [4:0] col,
  input  logic [1:0] dir,
  output logic [4:0] ahead_row,
  output logic [5:0] ahead_col,
  output logic       ahead_off,
  output logic [4:0] left_row,
  output logic [5:0] left_col,
  output logic       left_off
);

  localparam logic [4:0] ROW_MAX = 5'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);

  logic [4:0] row_x;
  logic [5:0] col_x;

  assign row_x = {1'b0, row};
  assign col_x = {1'b0, col};

  always_comb begin
    ahead_row = row_x;
    ahead_col = col_x;
    left_row  = row_x;
    left_col  = col_x;
    case (dir)
      NORTH: begin
        ahead_row = row_x - 5'd1;
        left_col  = col_x - 6'd1;
      end
      SOUTH: begin
        ahead_row = row_x + 5'd1;
        left_col  = col_x + 6'd1;
      end
      EAST: begin
        ahead_col = col_x + 6'd1;
        left_row  = row_x - 5'd1;
      end
      default: begin
        ahead_col = col_x - 6'd1;
        left_row  = row_x + 5'd1;
      end
    endcase
  end

  assign ahead_off = !in_map(ahead_row, ahead_col, ROW_MAX, COL_MAX);
  assign left_off  = !in_map(left_row, left_col, ROW_MAX, COL_MAX);

endmodule

// File: rtl/pipe_world_model.sv
// rtl/pipe_world_model.sv - pipe map and robot pose model closing the robot controller loop
module pipe_world_model
  import pipe_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int MAX_MOVES = MAX_MOVES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       map_we,
  input  logic [3:0] map_row,
  input  logic [4:0] map_col,
  input  logic [2:0] map_data,
  input  logic       start,
  input  logic [3:0] init_row,
  input  logic [4:0] init_col,
  input  logic [1:0] init_dir,
  input  logic       front,
  input  logic       turn,
  input  logic       remove,
  output logic       head,
  output logic       left,
  output logic       under,
  output logic       barrier,
  output logic [3:0] row,
  output logic [4:0] col,
  output logic [1:0] dir,
  output logic       running,
  output logic       error,
  output logic [8:0] moves,
  output logic [7:0] cleared
);

  localparam logic [4:0] ROW_MAX   = 5'(ROWS);
  localparam logic [5:0] COL_MAX   = 6'(COLS);
  localparam logic [8:0] MOVES_MAX = 9'(MAX_MOVES);

  state_t     state;
  logic [2:0] map_q [ROWS][COLS];
  logic [1:0] rm_cnt;

  logic [4:0] ahead_row, left_row;
  logic [5:0] ahead_col, left_col;
  logic       ahead_off, left_off;
  logic [2:0] ahead_cell, left_cell, cur_cell;

  logic       wr_en;
  logic [3:0] wr_r;
  logic [4:0] wr_c;
  logic [2:0] wr_d;

  logic       front_ok, rm_fire, rm_hit, init_ok, map_addr_ok;

  pipe_neighbour_lookup #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_nbr (
    .row      (row),
    .col      (col),
    .dir      (dir),
    .ahead_row(ahead_row),
    .ahead_col(ahead_col),
    .ahead_off(ahead_off),
    .left_row (left_row),
    .left_col (left_col),
    .left_off (left_off)
  );

  // Off-map reads return free so an out-of-range pose after a bad start is harmless.
  function automatic logic [2:0] cell_rd(input logic [4:0] r, input logic [5:0] c);
    logic [3:0] ri;
    logic [4:0] ci;
    ri = r[3:0] - 4'd1;
    ci = c[4:0] - 5'd1;
    if (!in_map(r, c, ROW_MAX, COL_MAX)) return CELL_FREE;
    return map_q[ri][ci];
  endfunction

  always_comb begin
    ahead_cell = cell_rd(ahead_row, ahead_col);
    left_cell  = cell_rd(left_row, left_col);
    cur_cell   = cell_rd({1'b0, row}, {1'b0, col});
  end

  assign head    = ahead_off || (ahead_cell == CELL_WALL);
  assign left    = left_off || (left_cell == CELL_WALL);
  assign under   = (cur_cell == CELL_UNDER);
  assign barrier = !ahead_off && (ahead_cell == CELL_TRASH);
  assign running = (state == ST_RUN);

  assign front_ok    = !ahead_off && (ahead_cell != CELL_WALL) && (ahead_cell != CELL_TRASH);
  assign rm_fire     = (state == ST_RUN) && remove && (rm_cnt == 2'd2);
  assign rm_hit      = rm_fire && !ahead_off && (ahead_cell == CELL_TRASH);
  assign init_ok     = in_map({1'b0, init_row}, {1'b0, init_col}, ROW_MAX, COL_MAX);
  assign map_addr_ok = in_map({1'b0, map_row}, {1'b0, map_col}, ROW_MAX, COL_MAX);

  // Single map write port: host loads in IDLE, trash removal in RUN.
  always_comb begin
    wr_en = 1'b0;
    wr_r  = ahead_row[3:0] - 4'd1;
    wr_c  = ahead_col[4:0] - 5'd1;
    wr_d  = CELL_FREE;
    if (state == ST_IDLE && map_we && map_addr_ok) begin
      wr_en = 1'b1;
      wr_r  = map_row - 4'd1;
      wr_c  = map_col - 5'd1;
      wr_d  = map_data;
    end else if (rm_hit) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          map_q[r][c] <= CELL_FREE;
        end
      end
    end else if (wr_en) begin
      map_q[wr_r][wr_c] <= wr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      row     <= 4'd1;
      col     <= 5'd1;
      dir     <= NORTH;
      rm_cnt  <= 2'd0;
      moves   <= 9'd0;
      cleared <= 8'd0;
      error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            row    <= init_row;
            col    <= init_col;
            dir    <= init_dir;
            moves  <= 9'd0;
            rm_cnt <= 2'd0;
            if (init_ok) begin
              state <= ST_RUN;
              error <= 1'b0;
            end else begin
              state <= ST_HALT;
              error <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          moves <= moves + 9'd1;
          if (front) begin
            if (front_ok) begin
              row <= ahead_row[3:0];
              col <= ahead_col[4:0];
            end else begin
              error <= 1'b1;
            end
          end else if (turn) begin
            dir <= turn_left(dir);
          end
          if (remove) begin
            if (rm_cnt == 2'd2) begin
              rm_cnt <= 2'd0;
              if (rm_hit && cleared != 8'hFF) cleared <= cleared + 8'd1;
            end else begin
              rm_cnt <= rm_cnt + 2'd1;
            end
          end
          if ((front && !front_ok) || (moves + 9'd1 == MOVES_MAX)) state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_world_model.sv
// tb/tb_pipe_world_model.sv - directed self-checking bench for pipe_world_model
module tb_pipe_world_model;
  import pipe_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       map_we = 1'b0;
  logic [3:0] map_row = 4'd0;
  logic [4:0] map_col = 5'd0;
  logic [2:0] map_data = 3'd0;
  logic       start = 1'b0;
  logic [3:0] init_row = 4'd0;
  logic [4:0] init_col = 5'd0;
  logic [1:0] init_dir = 2'd0;
  logic       front = 1'b0;
  logic       turn = 1'b0;
  logic       remove = 1'b0;
  logic       head, left, under, barrier, running, error;
  logic [3:0] row;
  logic [4:0] col;
  logic [1:0] dir;
  logic [8:0] moves;
  logic [7:0] cleared;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_world_model dut (
    .clock(clock), .reset(reset),
    .map_we(map_we), .map_row(map_row), .map_col(map_col), .map_data(map_data),
    .start(start), .init_row(init_row), .init_col(init_col), .init_dir(init_dir),
    .front(front), .turn(turn), .remove(remove),
    .head(head), .left(left), .under(under), .barrier(barrier),
    .row(row), .col(col), .dir(dir), .running(running), .error(error),
    .moves(moves), .cleared(cleared)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic write_cell(input logic [3:0] r, input logic [4:0] c, input logic [2:0] d);
    map_we = 1'b1; map_row = r; map_col = c; map_data = d;
    step();
    map_we = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] r, input logic [4:0] c, input logic [1:0] d);
    start = 1'b1; init_row = r; init_col = c; init_dir = d;
    step();
    start = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    step();
    chk("rst_row", row, 1);
    chk("rst_col", col, 1);
    chk("rst_dir", dir, 0);
    chk("rst_head", head, 1);
    chk("rst_left", left, 1);
    chk("rst_under", under, 0);
    chk("rst_barrier", barrier, 0);
    chk("rst_running", running, 0);
    chk("rst_error", error, 0);
    chk("rst_moves", moves, 0);
    chk("rst_cleared", cleared, 0);
    reset = 1'b1;
    step();
    front = 1'b1; turn = 1'b1; remove = 1'b1;
    step();
    front = 1'b0; turn = 1'b0; remove = 1'b0;
    chk("idle_ignore_row", row, 1);
    chk("idle_ignore_dir", dir, 0);
    chk("idle_running", running, 0);

    // Forward moves on a free map heading east.
    do_start(4'd5, 5'd5, EAST);
    chk("fwd_running", running, 1);
    chk("fwd_col0", col, 5);
    chk("fwd_moves0", moves, 0);
    front = 1'b1;
    step(); chk("fwd_col1", col, 6);
    step(); chk("fwd_col2", col, 7);
    step(); chk("fwd_col3", col, 8);
    front = 1'b0;
    chk("fwd_moves3", moves, 3);
    chk("fwd_head", head, 0);
    chk("fwd_row", row, 5);
    step();
    chk("fwd_idle_moves", moves, 4);
    chk("fwd_idle_col", col, 8);

    // Four left turns from north.
    do_reset();
    do_start(4'd5, 5'd5, NORTH);
    turn = 1'b1;
    step(); chk("turn_w", dir, 3);
    step(); chk("turn_s", dir, 1);
    step(); chk("turn_e", dir, 2);
    step(); chk("turn_n", dir, 0);
    turn = 1'b0;
    chk("turn_row", row, 5);
    chk("turn_col", col, 5);

    // Trash removal; map write and start share the same edge.
    do_reset();
    map_we = 1'b1; map_row = 4'd4; map_col = 5'd5; map_data = CELL_TRASH;
    do_start(4'd5, 5'd5, NORTH);
    map_we = 1'b0;
    chk("trash_barrier", barrier, 1);
    chk("trash_head", head, 0);
    remove = 1'b1; step(); remove = 1'b0; step();
    remove = 1'b1; step(); remove = 1'b0; step();
    chk("trash_barrier_2pulses", barrier, 1);
    chk("trash_cleared_2pulses", cleared, 0);
    remove = 1'b1; step(); remove = 1'b0;
    chk("trash_cleared", cleared, 1);
    chk("trash_barrier_gone", barrier, 0);
    front = 1'b1; step(); front = 1'b0;
    chk("trash_front_row", row, 4);
    chk("trash_error", error, 0);
    remove = 1'b1;
    step(); step(); step();
    remove = 1'b0;
    chk("nontrash_cleared", cleared, 1);

    // Blocked move at the top edge, then restart from HALT.
    do_reset();
    do_start(4'd1, 5'd3, NORTH);
    chk("edge_head", head, 1);
    chk("edge_left", left, 0);
    front = 1'b1; step(); front = 1'b0;
    chk("edge_error", error, 1);
    chk("edge_running", running, 0);
    chk("edge_row", row, 1);
    turn = 1'b1; step(); turn = 1'b0;
    chk("halt_dir_held", dir, 0);
    chk("halt_moves_held", moves, 1);
    do_start(4'd2, 5'd3, EAST);
    chk("restart_error", error, 0);
    chk("restart_running", running, 1);
    chk("restart_row", row, 2);
    chk("restart_moves", moves, 0);

    // Out-of-range initial pose from IDLE.
    do_reset();
    do_start(4'd0, 5'd3, NORTH);
    chk("badstart_error", error, 1);
    chk("badstart_running", running, 0);

    // Under-marker, left wall, and reset mid-run.
    do_reset();
    write_cell(4'd6, 5'd8, CELL_UNDER);
    write_cell(4'd5, 5'd7, CELL_WALL);
    do_start(4'd6, 5'd7, EAST);
    chk("under_before", under, 0);
    chk("left_wall", left, 1);
    front = 1'b1; step(); front = 1'b0;
    chk("under_after", under, 1);
    chk("under_col", col, 8);
    chk("left_free", left, 0);
    reset = 1'b0;
    #1;
    chk("abort_running", running, 0);
    chk("abort_row", row, 1);
    step();
    reset = 1'b1;
    step();
    do_start(4'd6, 5'd8, NORTH);
    chk("abort_map_cleared", under, 0);
    chk("abort_restart_running", running, 1);

    // Automatic stop after MAX_MOVES run cycles.
    do_reset();
    do_start(4'd3, 5'd3, SOUTH);
    repeat (510) step();
    chk("maxmv_moves510", moves, 510);
    chk("maxmv_running510", running, 1);
    step();
    chk("maxmv_moves511", moves, 511);
    chk("maxmv_running", running, 0);
    chk("maxmv_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_world_model.md
Name: pipe_world_model

Overview:
- Synthesizable pipe environment model that sits directly downstream of the robot controller and closes its loop.
- Consumes the controller's front/turn/remove commands and updates a 10x20 pipe map plus the robot pose.
- Produces the head/left/under/barrier sensor inputs the controller samples.
- Replaces the behavioural map/pose bookkeeping for on-chip and regression runs.

Parameters:
ROWS, 10, number of map rows (1-based, 1..ROWS)
COLS, 20, number of map columns (1-based, 1..COLS)
MAX_MOVES, 511, RUN cycles before automatic stop

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
map_we  in  1  map cell write strobe (IDLE only)
map_row  in  4  write row, 1..ROWS
map_col  in  5  write column, 1..COLS
map_data  in  3  cell code: 0 free, 1 wall, 2 trash, 7 under-marker
start  in  1  one-cycle pulse; loads initial pose, enters RUN
init_row  in  4  initial row
init_col  in  5  initial column
init_dir  in  2  initial orientation: 00 N, 01 S, 10 E, 11 W
front  in  1  controller: advance one cell
turn  in  1  controller: rotate left
remove  in  1  controller: remove-trash pulse
head  out  1  wall or edge ahead
left  out  1  wall or edge to robot's left
under  out  1  current cell is code 7
barrier  out  1  trash (code 2) ahead, in-map only
row  out  4  current row
col  out  5  current column
dir  out  2  current orientation
running  out  1  state == RUN
error  out  1  sticky anomaly flag
moves  out  9  RUN cycles elapsed
cleared  out  8  trash cells removed

Behaviour:
- Reset (async, active-low): state IDLE; pose row=1, col=1, dir=N; all map cells 0; remove counter 0; moves=0; cleared=0; error=0. Sensor outputs follow from this state (head=1, left=1, under=0, barrier=0).
- Reset asserted mid-RUN aborts immediately. No map contents survive reset.
- States: IDLE, RUN, HALT.
- IDLE:
  - map_we writes map_data to cell (map_row, map_col) at posedge.
  - Out-of-range addresses are ignored.
  - front/turn/remove are ignored.
- IDLE + start:
  - Load init pose; clear moves and the remove counter.
  - Go to RUN if the pose is in range, else set error and go to HALT.
  - If start and map_we occur in the same cycle, the write completes first.
- RUN, per posedge:
  - map_we is ignored.
  - moves increments every cycle.
  - moves reaching MAX_MOVES -> HALT with error=0.
- front (priority over turn):
  - Target cell in map and not 1/2: advance one cell (N row-1, S row+1, E col+1, W col-1).
  - Target off-map or code 1/2: pose unchanged, error=1, HALT.
- turn with front=0: N->W, W->S, S->E, E->N.
- remove:
  - Counter 0->1->2 on successive remove pulses; pulses need not be consecutive.
  - The third pulse clears the cell ahead of the pre-update pose to 0 if it holds code 2, increments cleared (saturating at 255), and returns the counter to 0.
  - If the cell ahead is not trash on the third pulse, the counter still returns to 0 and cleared is unchanged.
  - front, turn, or remove in the same cycle: the remove logic uses the pre-update pose.
- Sensors: combinational from the registered pose and map; a command at edge k is reflected after edge k.
  - head: cell ahead is off-map or code 1.
  - left: cell to the left (N:col-1, S:col+1, E:row-1, W:row+1) is off-map or code 1.
  - under: current cell is code 7.
  - barrier: cell ahead is in-map and code 2.
- HALT:
  - Commands are ignored; pose, map and counters are held.
  - start returns to RUN with the new pose; error is cleared on that start.
- Arithmetic: row/col computed with 1 extra bit so that row 0 / col 0 / ROWS+1 / COLS+1 detect off-map without wrap.

Decomposition:
- Shared package pipe_pkg holds:
  - direction constants NORTH=00, SOUTH=01, EAST=10, WEST=11;
  - cell codes CELL_FREE=0, CELL_WALL=1, CELL_TRASH=2, CELL_UNDER=7;
  - state encoding;
  - ROWS/COLS defaults.
- One sub-module, pipe_neighbour_lookup: pure combinational; given pose returns ahead/left coordinates and off-map flags. It is used for both sensor generation and move/remove targeting.

Test Plan:
- Reset then release: row=1, col=1, dir=00, head=1, left=1, running=0, error=0.
- Load 10x20 all-free map, start at (5,5,E), front x3: col 6,7,8 on successive edges; moves=3; head=0.
- Start at (5,5,N), turn x4: dir 11, 01, 10, 00; row/col unchanged.
- Cell (4,5)=2, start (5,5,N): barrier=1, head=0. Three separated remove pulses -> cell cleared, cleared=1, barrier=0 after the third edge. front then reaches row 4.
- Start (1,3,N), front: error=1, state HALT, row stays 1. A new start at (2,3,E) clears error, running=1.
- Cell (6,8)=7, start (6,7,E), front -> under=1. Asserting reset mid-RUN forces IDLE and map cell (6,8) reads 0 afterwards.
